sram_responder: RTL and testbench

Memory-side responder for the CPU's data and instruction ports. It accepts one request at a time over a valid/ready handshake and drives a single SRAM_wrapper macro through its active-low CEB/WEB/BWEB pins. It captures the macro's DO output and returns it over a valid/ready response channel. A configurable wait-state count lets the CPU be exercised against memory slower than one cycle.

---
 rtl/sram_responder_pkg.sv | 24 ++
 rtl/sram_responder.sv | 194 +++++++++++++++++++
 tb/tb_sram_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_resp_pkg
//   Shared definitions for the SRAM responder:
//     state_e     - responder FSM states (IDLE, ACCESS, DATA, WAIT, RESP)
//     WAIT_CNT_W  - width of the wait-state down-counter
//     BWEB_NONE   - all-ones bit-write-enable (no bit written); sliced to the
//                   data width by the user, so it is kept wide here
// -----------------------------------------------------------------------------
package sram_resp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCESS = 3'd1,
      DATA   = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_e;

   localparam int WAIT_CNT_W = 4;

   localparam int                    BWEB_MAX_W = 64;
   localparam logic [BWEB_MAX_W-1:0] BWEB_NONE  = '1;

endpackage

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   Memory-side responder for one CPU port. Takes one request at a time over a
//   valid/ready handshake, performs a single-cycle access on an SRAM macro
//   (active-low CEB/WEB/BWEB), captures the macro's DO one cycle later and
//   returns it over a valid/ready response channel after WAIT_CYCLES extra
//   cycles.
//
// Parameters
//   ADDR_W       SRAM word-address width (sram_A)
//   DATA_W       data width (<= 64)
//   WAIT_CYCLES  extra cycles before the response, 0..15
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    request present
//   req_ready    responder can take a request this cycle
//   req_we       1 = write, 0 = read
//   req_addr     byte address; only bits [ADDR_W+1:2] are used
//   req_wdata    write data
//   req_bweb     per-bit write mask, active-low
//   rsp_valid    response present
//   rsp_ready    consumer takes the response
//   rsp_rdata    read data (zero for write acknowledgements)
//   rsp_write    1 = write acknowledgement
//   sram_CEB     macro chip enable, active-low (registered)
//   sram_WEB     macro write enable, active-low (registered)
//   sram_BWEB    macro bit-write enable, active-low (registered)
//   sram_A       macro word address (registered)
//   sram_DI      macro write data (registered)
//   sram_DO      macro read data, valid the cycle after the access cycle
// -----------------------------------------------------------------------------
module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [DATA_W-1:0] req_bweb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_write,
   output logic              sram_CEB,
   output logic              sram_WEB,
   output logic [DATA_W-1:0] sram_BWEB,
   output logic [ADDR_W-1:0] sram_A,
   output logic [DATA_W-1:0] sram_DI,
   input  logic [DATA_W-1:0] sram_DO
);

   localparam logic [DATA_W-1:0] BWEB_ALL = BWEB_NONE[DATA_W-1:0];

   // Counter start value on WAIT entry; WAIT then lasts WAIT_CYCLES cycles.
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   state_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q,   cnt_d;
   logic                    ceb_q,   ceb_d;
   logic                    web_q,   web_d;
   logic [DATA_W-1:0]       bweb_q,  bweb_d;
   logic [ADDR_W-1:0]       a_q,     a_d;
   logic [DATA_W-1:0]       di_q,    di_d;
   logic                    we_q,    we_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    write_q, write_d;

   logic                    accept;

   // Byte-offset bits and address bits above the macro range alias away.
   logic                    unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   // A request can be taken from IDLE, or from RESP in the same edge that
   // retires the current response.
   assign req_ready = rst & ((state_q == IDLE) | ((state_q == RESP) & rsp_ready));
   assign accept    = req_valid & req_ready;

   // -------------------------------------------------------------------------
   // Next-state and registered-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ceb_d   = ceb_q;
      web_d   = web_q;
      bweb_d  = bweb_q;
      a_d     = a_q;
      di_d    = di_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      write_d = write_q;

      case (state_q)
         IDLE: begin
            state_d = IDLE;
         end
         ACCESS: begin
            // Single access cycle ends: release the macro controls.
            ceb_d   = 1'b1;
            web_d   = 1'b1;
            bweb_d  = BWEB_ALL;
            state_d = DATA;
         end
         DATA: begin
            // DO is valid now; writes return zero data.
            rdata_d = we_q ? '0 : sram_DO;
            write_d = we_q;
            if (WAIT_CYCLES > 0) begin
               state_d = WAIT;
               cnt_d   = WAIT_LOAD;
            end else begin
               state_d = RESP;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - WAIT_CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Acceptance (from IDLE or RESP) overrides the plain transitions above
      // and drives the access cycle directly from the request.
      if (accept) begin
         state_d = ACCESS;
         ceb_d   = 1'b0;
         web_d   = ~req_we;
         bweb_d  = req_we ? req_bweb : BWEB_ALL;
         a_d     = req_addr[ADDR_W+1:2];
         di_d    = req_wdata;
         we_d    = req_we;
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ceb_q   <= 1'b1;
         web_q   <= 1'b1;
         bweb_q  <= BWEB_ALL;
         a_q     <= '0;
         di_q    <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ceb_q   <= ceb_d;
         web_q   <= web_d;
         bweb_q  <= bweb_d;
         a_q     <= a_d;
         di_q    <= di_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         write_q <= write_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_write = write_q;
   assign sram_CEB  = ceb_q;
   assign sram_WEB  = web_q;
   assign sram_BWEB = bweb_q;
   assign sram_A    = a_q;
   assign sram_DI   = di_q;

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//   Two responders (WAIT_CYCLES = 0 and 2), each driving its own behavioural
//   SRAM macro. A table of directed transactions, hand-written reset and
//   back-to-back sequences, and random traffic are checked against a
//   word-addressed reference memory.
// -----------------------------------------------------------------------------
module tb_sram_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [31:0] req_bweb   [2];
   logic        rsp_valid  [2];
   logic        rsp_ready  [2];
   logic [31:0] rsp_rdata  [2];
   logic        rsp_write  [2];
   logic        sram_CEB   [2];
   logic        sram_WEB   [2];
   logic [31:0] sram_BWEB  [2];
   logic [13:0] sram_A     [2];
   logic [31:0] sram_DI    [2];

   int vectors     = 0;
   int miscompares = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] do_q;
      logic [31:0] mem [16384];
      logic        init_done = 1'b0;

      sram_responder #(
         .ADDR_W      (14),
         .DATA_W      (32),
         .WAIT_CYCLES ((g == 0) ? 0 : 2)
      ) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_bweb  (req_bweb[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_write (rsp_write[g]),
         .sram_CEB  (sram_CEB[g]),
         .sram_WEB  (sram_WEB[g]),
         .sram_BWEB (sram_BWEB[g]),
         .sram_A    (sram_A[g]),
         .sram_DI   (sram_DI[g]),
         .sram_DO   (do_q)
      );

      // Behavioural macro: unwritten word w reads 0x5A5A0000 ^ w.
      always @(posedge clk) begin
         if (!init_done) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'h5A5A_0000 ^ 32'(i);
            init_done <= 1'b1;
         end else if (!sram_CEB[g]) begin
            if (!sram_WEB[g])
               mem[sram_A[g]] <= (mem[sram_A[g]] & sram_BWEB[g]) | (sram_DI[g] & ~sram_BWEB[g]);
            do_q <= mem[sram_A[g]];
         end
      end
   end

   // Reference memory, key = instance*65536 + word address.
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] ref_access(input int d, input logic we,
                                              input logic [31:0] addr, wdata, bweb);
      int          k;
      logic [31:0] w;
      logic [31:0] old;
      w   = (addr >> 2) & 32'h3FFF;
      k   = d * 65536 + int'(w);
      old = ref_mem.exists(k) ? ref_mem[k] : (32'h5A5A_0000 ^ w);
      if (we) begin
         ref_mem[k] = (old & bweb) | (wdata & ~bweb);
         return 32'h0;
      end
      return old;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic rst_pulse(input int d);
      @(negedge clk);
      rst[d] = 1'b0;
      #1;
      chk("rst_CEB",       32'(sram_CEB[d]),  32'h1);
      chk("rst_WEB",       32'(sram_WEB[d]),  32'h1);
      chk("rst_BWEB",      sram_BWEB[d],      32'hFFFF_FFFF);
      chk("rst_A",         32'(sram_A[d]),    32'h0);
      chk("rst_DI",        sram_DI[d],        32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata[d],      32'h0);
      chk("rst_rsp_write", 32'(rsp_write[d]), 32'h0);
      chk("rst_req_ready", 32'(req_ready[d]), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst[d] = 1'b1;
      #1;
      chk("post_rst_req_ready", 32'(req_ready[d]), 32'h1);
   endtask

   // One complete transaction; hold>0 keeps rsp_ready low for that many
   // cycles in RESP while a second request is offered.
   task automatic txn(input int d, input logic we, input logic [31:0] addr, wdata, bweb,
                      input int hold, input int exp_lat,
                      output logic [31:0] rdata, output logic wr);
      int          n;
      int          lat;
      int          ceb_cnt;
      logic        nwe;
      logic [31:0] exp_a;
      logic [31:0] exp_bweb;
      exp_a    = (addr >> 2) & 32'h3FFF;
      nwe      = ~we;
      exp_bweb = we ? bweb : 32'hFFFF_FFFF;
      rdata    = 32'h0;
      wr       = 1'b0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_bweb[d]  = bweb;
      rsp_ready[d] = (hold == 0);
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(req_ready[d]), 32'h1);
      if (!req_ready[d]) begin
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      req_wdata[d] = $urandom;
      req_bweb[d]  = $urandom;
      lat     = 1;
      ceb_cnt = 0;
      while (!rsp_valid[d] && lat < 40) begin
         if (!sram_CEB[d]) begin
            ceb_cnt++;
            chk("acc_A",    32'(sram_A[d]),   exp_a);
            chk("acc_WEB",  32'(sram_WEB[d]), 32'(nwe));
            chk("acc_BWEB", sram_BWEB[d],     exp_bweb);
            chk("acc_DI",   sram_DI[d],       wdata);
         end
         @(negedge clk);
         lat++;
      end
      chk("rsp_valid_wait", 32'(rsp_valid[d]), 32'h1);
      chk("latency",        32'(lat),          32'(exp_lat));
      chk("ceb_pulses",     32'(ceb_cnt),      32'h1);
      rdata = rsp_rdata[d];
      wr    = rsp_write[d];
      if (hold > 0) begin
         req_valid[d] = 1'b1;
         req_we[d]    = 1'b0;
         req_addr[d]  = 32'h0;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'h1);
            chk("hold_rsp_rdata", rsp_rdata[d],      rdata);
            chk("hold_req_ready", 32'(req_ready[d]), 32'h0);
            chk("hold_CEB",       32'(sram_CEB[d]),  32'h1);
         end
         req_valid[d] = 1'b0;
         rsp_ready[d] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'h0);
   endtask

   typedef struct {
      logic        rst_before;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] bweb;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_write;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        wr;
      logic [31:0] e;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] bw;
      logic        we;
      int          d;
      int          cyc;
      int          idx;
      logic        pend;
      int          acc [$];
      logic [31:0] got [$];
      logic [31:0] expq [$];
      logic [31:0] b2b_addr [4];

      tbl[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0000_0000, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hAAAA_AAAA, 32'h0000_0000, 0, 32'h0000_0000, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'hFFFF_0000, 0, 32'h0000_0000, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 5, 32'hAAAA_5678, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 32'h0001_0043, 32'h0000_0000, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h1111_1111, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 32'h0000_0048, 32'h0000_0000, 32'h0000_0000, 0, 32'h5A5A_0012, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 32'h0000_0000, 0, 32'h0000_0000, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h0003_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'h0000_004C, 32'hFFFF_FFFF, 32'h0000_FFFF, 0, 32'h0000_0000, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0000_0000, 32'h0000_0000, 2, 32'hFFFF_0013, 1'b0};

      for (int i = 0; i < 2; i++) begin
         rst[i]       = 1'b0;
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
         req_bweb[i]  = 32'hFFFF_FFFF;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      rst[0] = 1'b1;
      rst[1] = 1'b1;

      rst_pulse(0);
      rst_pulse(1);

      // Directed table on the zero-wait-state responder.
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst_before) rst_pulse(0);
         e = ref_access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].bweb);
         txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].bweb, tbl[i].hold, 3, rd, wr);
         chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_write", i), 32'(wr), 32'(tbl[i].exp_write));
      end

      // Reset during the ACCESS cycle: CEB must release asynchronously.
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h40; rsp_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("mid_access_CEB_low", 32'(sram_CEB[0]), 32'h0);
      rst[0] = 1'b0;
      #1;
      chk("mid_access_CEB_rel", 32'(sram_CEB[0]), 32'h1);
      @(negedge clk);
      rst[0] = 1'b1;

      // Reset during the DATA cycle: the request is dropped with no response.
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h40;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b0;
      #1;
      chk("mid_data_CEB",       32'(sram_CEB[0]),  32'h1);
      chk("mid_data_rsp_valid", 32'(rsp_valid[0]), 32'h0);
      @(negedge clk);
      rst[0] = 1'b1;
      #1;
      chk("mid_data_req_ready", 32'(req_ready[0]), 32'h1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("dropped_no_rsp", 32'(rsp_valid[0]), 32'h0);
      end
      e = ref_access(0, 1'b0, 32'h40, 32'h0, 32'h0);
      txn(0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 3, rd, wr);
      chk("after_rst_read", rd, e);

      // Two-wait-state responder: preload four words.
      for (int i = 0; i < 4; i++) begin
         b2b_addr[i] = 32'h100 + 32'(i * 4);
         wd = $urandom;
         e  = ref_access(1, 1'b1, b2b_addr[i], wd, 32'h0);
         txn(1, 1'b1, b2b_addr[i], wd, 32'h0, 0, 5, rd, wr);
         chk("w2_write_ack", 32'(wr), 32'h1);
         chk("w2_write_rdata", rd, e);
      end

      // Back-to-back reads with rsp_ready held high.
      for (int i = 0; i < 4; i++) expq.push_back(ref_access(1, 1'b0, b2b_addr[i], 32'h0, 32'h0));
      rsp_ready[1] = 1'b1;
      @(negedge clk);
      idx  = 0;
      cyc  = 0;
      pend = 1'b0;
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = b2b_addr[0];
      for (int t = 0; t < 80 && got.size() < 4; t++) begin
         if (req_valid[1] && req_ready[1]) begin
            acc.push_back(cyc);
            pend = 1'b1;
         end
         if (rsp_valid[1]) got.push_back(rsp_rdata[1]);
         @(negedge clk);
         cyc++;
         if (pend) begin
            pend = 1'b0;
            idx++;
            if (idx < 4) req_addr[1] = b2b_addr[idx];
            else         req_valid[1] = 1'b0;
         end
      end
      req_valid[1] = 1'b0;
      chk("b2b_rsp_count", 32'(got.size()), 32'h4);
      chk("b2b_acc_count", 32'(acc.size()), 32'h4);
      for (int i = 1; i < 4 && i < acc.size(); i++)
         chk($sformatf("b2b_interval%0d", i), 32'(acc[i] - acc[i-1]), 32'h5);
      for (int i = 0; i < 4 && i < got.size(); i++)
         chk($sformatf("b2b_data%0d", i), got[i], expq[i]);
      @(negedge clk);

      // Random traffic on both responders over a small aliased window.
      for (int i = 0; i < 40; i++) begin
         d  = i % 2;
         we = 1'($urandom_range(0, 1));
         a  = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(32'h20, 32'h27)) << 2);
         wd = $urandom;
         case ($urandom_range(0, 3))
            0:       bw = 32'h0;
            1:       bw = 32'hFFFF_FFFF;
            default: bw = $urandom;
         endcase
         e = ref_access(d, we, a, wd, bw);
         txn(d, we, a, wd, bw, $urandom_range(0, 2), (d == 0) ? 3 : 5, rd, wr);
         chk("rand_rdata", rd, e);
         chk("rand_write", 32'(wr), 32'(we));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
